// File: rtl/vector_types_pkg.sv
`default_nettype none
// ============================================================================
// vector_types_pkg : shared types/constants for the vector element sequencers
// Rev 1.0
// ============================================================================
package vector_types_pkg;

    localparam int VLMAX_DEFAULT     = 32;
    localparam int NUM_LANES_DEFAULT = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } ecount_state_t;

    typedef logic [$clog2(VLMAX_DEFAULT):0]   vl_t;
    typedef logic [$clog2(VLMAX_DEFAULT)-1:0] elem_idx_t;

endpackage
`default_nettype wire

// File: rtl/vector_element_counter_if.sv
`default_nettype none
// ============================================================================
// vector_element_counter_if : control-unit / lane handshake of the element counter
// Rev 1.0
// ============================================================================
interface vector_element_counter_if
    import vector_types_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEFAULT,
    parameter int VLMAX     = VLMAX_DEFAULT
);
    logic                       start;
    logic [$clog2(VLMAX):0]     vl;
    logic [$clog2(VLMAX)-1:0]   vstart;
    logic                       widen;
    logic                       stall;
    logic                       flush;
    logic                       ready;
    logic                       busy;
    logic [$clog2(VLMAX)-1:0]   offset;
    logic [NUM_LANES-1:0]       lane_active;
    logic                       done;

    modport master (
        output start, vl, vstart, widen, stall, flush,
        input  ready, busy, offset, lane_active, done
    );

    modport slave (
        input  start, vl, vstart, widen, stall, flush,
        output ready, busy, offset, lane_active, done
    );

endinterface
`default_nettype wire

// File: rtl/vector_lane_mask_gen.sv
`default_nettype none
// ============================================================================
// vector_lane_mask_gen : per-lane active mask and last-beat flag for one beat
// Rev 1.0
// ============================================================================
module vector_lane_mask_gen
    import vector_types_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEFAULT,
    parameter int VLMAX     = VLMAX_DEFAULT
) (
    input  wire logic [$clog2(VLMAX)-1:0] offset_i,
    input  wire logic [$clog2(VLMAX):0]   vl_i,
    input  wire logic [$clog2(VLMAX):0]   step_i,
    output logic      [NUM_LANES-1:0]     lane_active_o,
    output logic                          last_o
);
    // Two extra bits so offset+step and offset+lane never wrap.
    localparam int EXT_W = $clog2(VLMAX) + 2;

    logic [EXT_W-1:0] w_end;

    assign w_end  = EXT_W'(offset_i) + EXT_W'(step_i);
    assign last_o = (w_end >= EXT_W'(vl_i));

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_active_o[i] = ((EXT_W'(offset_i) + EXT_W'(i)) < EXT_W'(vl_i));
    end

endmodule
`default_nettype wire

// File: rtl/vector_element_counter.sv
`default_nettype none
// ============================================================================
// vector_element_counter : walks vstart..vl-1, NUM_LANES elements per beat
// Optional half-rate widening step: VECTOR_ELEM_COUNTER_WIDEN_EN      Rev 1.0
// ============================================================================
module vector_element_counter
    import vector_types_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEFAULT,
    parameter int VLMAX     = VLMAX_DEFAULT
) (
    input  wire logic                   CLK,
    input  wire logic                   RST,
    vector_element_counter_if.slave     bus
);
    localparam int IDX_W = $clog2(VLMAX);
    localparam int VL_W  = IDX_W + 1;

    ecount_state_t          state_q, state_d;
    logic [IDX_W-1:0]       offset_q, offset_d;
    logic [VL_W-1:0]        vl_q, vl_d;
    logic [VL_W-1:0]        w_step;
    logic [NUM_LANES-1:0]   w_mask;
    logic [NUM_LANES-1:0]   w_lane_keep;
    logic                   w_last;
    logic                   w_busy;
    logic                   w_accept;

`ifdef VECTOR_ELEM_COUNTER_WIDEN_EN
    localparam logic [NUM_LANES-1:0] HALF_MASK = NUM_LANES'({(NUM_LANES/2){1'b1}});

    logic widen_q, widen_d;

    assign w_step      = widen_q ? VL_W'(NUM_LANES/2) : VL_W'(NUM_LANES);
    assign w_lane_keep = widen_q ? HALF_MASK : '1;
`else
    logic w_widen_unused;

    assign w_widen_unused = bus.widen;
    assign w_step         = VL_W'(NUM_LANES);
    assign w_lane_keep    = '1;
`endif

    vector_lane_mask_gen #(
        .NUM_LANES (NUM_LANES),
        .VLMAX     (VLMAX)
    ) u_mask_gen (
        .offset_i      (offset_q),
        .vl_i          (vl_q),
        .step_i        (w_step),
        .lane_active_o (w_mask),
        .last_o        (w_last)
    );

    assign w_busy          = (state_q == COUNT);
    assign bus.busy        = w_busy;
    assign bus.offset      = offset_q;
    assign bus.done        = w_busy & w_last;
    assign bus.lane_active = w_busy ? (w_mask & w_lane_keep) : '0;
    assign bus.ready       = (state_q == IDLE) | (w_busy & w_last & ~bus.stall & ~bus.flush);
    assign w_accept        = bus.start & bus.ready & ~bus.flush;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        vl_d     = vl_q;
`ifdef VECTOR_ELEM_COUNTER_WIDEN_EN
        widen_d  = widen_q;
`endif
        if (bus.flush) begin
            state_d  = IDLE;
            offset_d = '0;
        end else if (w_accept) begin
            // Covers both a fresh start from IDLE and a bubble-free reload on the last beat.
            state_d  = COUNT;
            offset_d = bus.vstart;
            vl_d     = bus.vl;
`ifdef VECTOR_ELEM_COUNTER_WIDEN_EN
            widen_d  = bus.widen;
`endif
        end else if (w_busy && !bus.stall) begin
            if (w_last) begin
                state_d = IDLE;
            end else begin
                offset_d = offset_q + w_step[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            offset_q <= '0;
            vl_q     <= '0;
`ifdef VECTOR_ELEM_COUNTER_WIDEN_EN
            widen_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            vl_q     <= vl_d;
`ifdef VECTOR_ELEM_COUNTER_WIDEN_EN
            widen_q  <= widen_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_element_counter.sv
`default_nettype none
// ============================================================================
// tb_vector_element_counter : table + scoreboard bench for vector_element_counter
// Rev 1.0
// ============================================================================
module tb_vector_element_counter;
    import vector_types_pkg::*;

    localparam int NL = 2;
    localparam int VM = 32;
`ifdef VECTOR_ELEM_COUNTER_WIDEN_EN
    localparam bit WIDEN_ON = 1'b1;
`else
    localparam bit WIDEN_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    vector_element_counter_if #(.NUM_LANES(NL), .VLMAX(VM)) bus ();

    vector_element_counter #(
        .NUM_LANES (NL),
        .VLMAX     (VM)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        int offset;
        int lanes;
        int done;
    } beat_t;

    typedef struct {
        int vl;
        int vs;
        bit wd;
        int beats;
    } vec_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    passed   = 0;
    int    beat_cnt = 0;
    int    done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference walk of one instruction, one entry per expected beat.
    function automatic void model(input int vl, input int vs, input bit wd);
        int    step;
        int    e;
        bit    last;
        beat_t b;
        step = (wd && WIDEN_ON) ? NL / 2 : NL;
        e    = vs;
        do begin
            b.offset = e;
            b.lanes  = 0;
            for (int i = 0; i < NL; i++)
                if (i < step && e + i < vl) b.lanes |= (1 << i);
            last   = (e + step >= vl);
            b.done = last ? 1 : 0;
            exp_q.push_back(b);
            e += step;
        end while (!last);
    endfunction

    // Scoreboard: every busy cycle must match the head of the expectation queue.
    always @(negedge CLK) begin
        if (RST === 1'b0 && bus.busy === 1'b1) begin
            if (bus.done === 1'b1) done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                chk("offset", int'(bus.offset), exp_q[0].offset);
                chk("lane_active", int'(bus.lane_active), exp_q[0].lanes);
                chk("done", int'(bus.done), exp_q[0].done);
                chk("ready", int'(bus.ready),
                    (exp_q[0].done != 0 && !bus.stall && !bus.flush) ? 1 : 0);
                if (bus.flush) exp_q.delete();
                else if (!bus.stall) begin
                    void'(exp_q.pop_front());
                    beat_cnt++;
                end
            end
        end
    end

    task automatic drive(input int vl, input int vs, input bit wd);
        bus.vl     = 6'(vl);
        bus.vstart = 5'(vs);
        bus.widen  = wd;
        bus.start  = 1'b1;
    endtask

    task automatic accept();
        bit ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (bus.ready && !bus.flush) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic issue(input int vl, input int vs, input bit wd);
        model(vl, vs, wd);
        drive(vl, vs, wd);
        accept();
        bus.start = 1'b0;
        wait_idle();
    endtask

    vec_t tv[9];

    initial begin
        tv[0] = '{5,  0,  1'b0, 3};
        tv[1] = '{0,  0,  1'b0, 1};
        tv[2] = '{3,  3,  1'b0, 1};
        tv[3] = '{3,  0,  1'b1, WIDEN_ON ? 3 : 2};
        tv[4] = '{32, 0,  1'b0, 16};
        tv[5] = '{7,  4,  1'b0, 2};
        tv[6] = '{1,  0,  1'b0, 1};
        tv[7] = '{32, 31, 1'b0, 1};
        tv[8] = '{9,  31, 1'b0, 1};

        bus.start  = 1'b0;
        bus.vl     = '0;
        bus.vstart = '0;
        bus.widen  = 1'b0;
        bus.stall  = 1'b0;
        bus.flush  = 1'b0;
        RST        = 1'b1;
        #3;
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_lane_active", int'(bus.lane_active), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_offset", int'(bus.offset), 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int k = 0; k < 9; k++) begin
            beat_cnt = 0;
            issue(tv[k].vl, tv[k].vs, tv[k].wd);
            chk("table_beats", beat_cnt, tv[k].beats);
        end

        // Stall for two cycles on the last beat: done held for three cycles.
        beat_cnt = 0;
        done_cnt = 0;
        model(4, 0, 1'b0);
        drive(4, 0, 1'b0);
        accept();
        bus.start = 1'b0;
        @(posedge CLK); #1;
        bus.stall = 1'b1;
        @(posedge CLK); #1;
        chk("stall_hold_offset", int'(bus.offset), 2);
        @(posedge CLK); #1;
        bus.stall = 1'b0;
        @(posedge CLK); #1;
        chk("stall_then_idle", int'(bus.busy), 0);
        chk("stall_beats", beat_cnt, 2);
        chk("stall_done_cycles", done_cnt, 3);

        // Flush with start held on the offset=2 beat.
        done_cnt = 0;
        model(8, 0, 1'b0);
        drive(8, 0, 1'b0);
        accept();
        @(posedge CLK); #1;
        bus.flush = 1'b1;
        @(posedge CLK); #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("flush_busy", int'(bus.busy), 0);
        chk("flush_done", int'(bus.done), 0);
        chk("flush_lanes", int'(bus.lane_active), 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("flush_no_accept", int'(bus.busy), 0);
        chk("flush_done_count", done_cnt, 0);
        chk("flush_queue", exp_q.size(), 0);

        // Back-to-back: vl=2 then vl=3, start held, no bubble.
        beat_cnt = 0;
        done_cnt = 0;
        model(2, 0, 1'b0);
        model(3, 0, 1'b0);
        drive(2, 0, 1'b0);
        accept();
        bus.vl = 6'd3;
        accept();
        chk("b2b_no_bubble", int'(bus.busy), 1);
        chk("b2b_reload_offset", int'(bus.offset), 0);
        bus.start = 1'b0;
        wait_idle();
        chk("b2b_beats", beat_cnt, 3);
        chk("b2b_done_pulses", done_cnt, 2);

        // Asynchronous reset in the middle of a walk.
        done_cnt = 0;
        model(8, 0, 1'b0);
        drive(8, 0, 1'b0);
        accept();
        bus.start = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_offset", int'(bus.offset), 0);
        chk("midrst_ready", int'(bus.ready), 1);
        exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_stays_idle", int'(bus.busy), 0);

        chk("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
